gctr_stream: RTL and testbench

- Streaming GCTR engine (NIST SP 800-38D §6.5) for messages of arbitrary byte length, supplied block by block, rather than as one fixed-width vector.
- Issues each counter block to an external AES block-cipher core over a request/response handshake, XORs the returned keystream with incoming 128-bit data blocks, and emits the result with valid/ready backpressure.
- Masks the partial final block and advances the counter with inc_s on the low INC_WIDTH bits.
- Sits between the GCM data path and the shared AES core; replaces the fully-unrolled, one-cipher-instance-per-block counter structure.

---
 rtl/gctr_stream.sv | 195 +++++++++++++++++++
 tb/tb_gctr_stream.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gctr_stream.sv
// Streaming GCTR engine: one counter block per data block through a shared
// AES core, XOR with incoming data, partial-final-block masking.
module gctr_stream #(
    parameter int BLOCK_WIDTH = 128,
    parameter int INC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BLOCK_WIDTH-1:0] icb_in,
    input  logic [LEN_WIDTH-1:0]   len_in,
    output logic                   busy,
    output logic                   done,
    output logic                   aes_req_valid,
    input  logic                   aes_req_ready,
    output logic [BLOCK_WIDTH-1:0] aes_req_block,
    input  logic                   aes_rsp_valid,
    input  logic [BLOCK_WIDTH-1:0] aes_rsp_block,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [BLOCK_WIDTH-1:0] din_block,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [BLOCK_WIDTH-1:0] dout_block,
    output logic [4:0]             dout_bytes,
    output logic                   dout_last
);

    localparam int NB = BLOCK_WIDTH / 8;
    localparam int CW = LEN_WIDTH - 3;
    localparam logic [BLOCK_WIDTH-1:0] LOW_MASK =
        {BLOCK_WIDTH{1'b1}} >> (BLOCK_WIDTH - INC_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_KS,
        S_XOR,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [BLOCK_WIDTH-1:0] cb_q, cb_d;
    logic [CW-1:0]          rem_q, rem_d;
    logic [4:0]             lb_q, lb_d;
    logic [BLOCK_WIDTH-1:0] ks_q, ks_d;
    logic [BLOCK_WIDTH-1:0] dblk_q, dblk_d;
    logic [4:0]             dbytes_q, dbytes_d;
    logic                   dlast_q, dlast_d;
    logic                   dvalid_q, dvalid_d;
    logic                   done_q, done_d;

    logic [CW-1:0]          n_in;
    logic [4:0]             lb_in;
    logic                   final_blk;
    logic [4:0]             nbytes;
    logic [BLOCK_WIDTH-1:0] cb_inc;

    // Byte-lane mask: byte 0 sits in the top lane; lanes >= nb are zeroed.
    function automatic logic [BLOCK_WIDTH-1:0] byte_mask(input logic [4:0] nb);
        logic [BLOCK_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nb)) begin
                m[BLOCK_WIDTH-1-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    // Block count and final-block byte count derived from the byte length.
    always_comb begin
        n_in  = CW'(len_in[LEN_WIDTH-1:4]) + CW'(len_in[3:0] != 4'd0);
        lb_in = (len_in[3:0] == 4'd0) ? 5'd16 : {1'b0, len_in[3:0]};
    end

    // inc_s: only the low INC_WIDTH bits count; no carry into the upper field.
    always_comb begin
        cb_inc = (cb_q & ~LOW_MASK)
               | ((cb_q + BLOCK_WIDTH'(1)) & LOW_MASK);
    end

    assign final_blk = (rem_q == CW'(1));

    // Next-state, datapath loads and handshake outputs.
    always_comb begin
        state_d       = state_q;
        cb_d          = cb_q;
        rem_d         = rem_q;
        lb_d          = lb_q;
        ks_d          = ks_q;
        dblk_d        = dblk_q;
        dbytes_d      = dbytes_q;
        dlast_d       = dlast_q;
        dvalid_d      = dvalid_q;
        done_d        = 1'b0;
        nbytes        = 5'd16;
        aes_req_valid = 1'b0;
        din_ready     = 1'b0;

        if (dvalid_q && dout_ready) begin
            dvalid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cb_d    = icb_in;
                        rem_d   = n_in;
                        lb_d    = lb_in;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                aes_req_valid = 1'b1;
                if (aes_req_ready) begin
                    state_d = S_WAIT_KS;
                end
            end
            S_WAIT_KS: begin
                if (aes_rsp_valid) begin
                    ks_d    = aes_rsp_block;
                    state_d = S_XOR;
                end
            end
            S_XOR: begin
                din_ready = !dvalid_q || dout_ready;
                if (din_valid && din_ready) begin
                    nbytes   = final_blk ? lb_q : 5'd16;
                    dblk_d   = (din_block ^ ks_q) & byte_mask(nbytes);
                    dbytes_d = nbytes;
                    dlast_d  = final_blk;
                    dvalid_d = 1'b1;
                    rem_d    = rem_q - CW'(1);
                    if (final_blk) begin
                        state_d = S_DRAIN;
                    end else begin
                        cb_d    = cb_inc;
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (dvalid_q && dout_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cb_q     <= '0;
            rem_q    <= '0;
            lb_q     <= '0;
            ks_q     <= '0;
            dblk_q   <= '0;
            dbytes_q <= '0;
            dlast_q  <= 1'b0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cb_q     <= cb_d;
            rem_q    <= rem_d;
            lb_q     <= lb_d;
            ks_q     <= ks_d;
            dblk_q   <= dblk_d;
            dbytes_q <= dbytes_d;
            dlast_q  <= dlast_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign aes_req_block = cb_q;
    assign dout_valid    = dvalid_q;
    assign dout_block    = dblk_q;
    assign dout_bytes    = dbytes_q;
    assign dout_last     = dlast_q;

endmodule

// File: tb/tb_gctr_stream.sv
// Bench for gctr_stream: vector table plus scoreboard, AES modelled as
// identity cipher answering 3 cycles after request acceptance.
module tb_gctr_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] icb_in = '0;
    logic [19:0]  len_in = '0;
    logic         busy, done;
    logic         aes_req_valid;
    logic         aes_req_ready = 1'b1;
    logic [127:0] aes_req_block;
    logic         aes_rsp_valid = 1'b0;
    logic [127:0] aes_rsp_block = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] din_block = '0;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic [127:0] dout_block;
    logic [4:0]   dout_bytes;
    logic         dout_last;

    gctr_stream dut (
        .clk(clk), .rst(rst_n), .start(start),
        .icb_in(icb_in), .len_in(len_in),
        .busy(busy), .done(done),
        .aes_req_valid(aes_req_valid), .aes_req_ready(aes_req_ready),
        .aes_req_block(aes_req_block),
        .aes_rsp_valid(aes_rsp_valid), .aes_rsp_block(aes_rsp_block),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_block(din_block),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_block(dout_block), .dout_bytes(dout_bytes),
        .dout_last(dout_last)
    );

    typedef struct {
        logic [127:0] blk;
        logic [4:0]   bytes;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] icb;
        int           len;
        logic [127:0] din;
        int           exp_n;
        int           exp_lb;
        logic [127:0] exp_final;
        bit           busy_start;
    } vec_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           pop_cnt = 0;
    int           last_acc_cyc = 0;
    logic [127:0] last_blk = '0;
    logic [4:0]   last_bytes = '0;
    bit           req_seen = 1'b0;

    initial begin
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] bmask(input int nb);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < nb) m[127-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic [127:0] inc32(input logic [127:0] c);
        return {c[127:32], c[31:0] + 32'd1};
    endfunction

    // AES model: identity cipher, response 3 cycles after acceptance.
    initial begin
        int           cnt;
        logic [127:0] pend;
        cnt = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            aes_rsp_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    aes_rsp_valid = 1'b1;
                    aes_rsp_block = pend;
                end
            end
            if (rst_n && aes_req_valid && aes_req_ready) begin
                cnt  = 3;
                pend = aes_req_block;
            end
        end
    end

    // Output monitor: pops the scoreboard on each accepted dout.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (aes_req_valid) req_seen = 1'b1;
            if (rst_n && dout_valid && dout_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_dout: got %h required none",
                             dout_block);
                end else begin
                    e = sb.pop_front();
                    check("dout_block", dout_block, e.blk);
                    check("dout_bytes", 128'(dout_bytes), 128'(e.bytes));
                    check("dout_last", 128'(dout_last), 128'(e.last));
                    if (dout_last) begin
                        last_blk     = dout_block;
                        last_bytes   = dout_bytes;
                        last_acc_cyc = cyc;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic send(input logic [127:0] d, input exp_t e);
        int t;
        t = 0;
        din_block = d;
        din_valid = 1'b1;
        #1;
        while (!din_ready && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!din_ready) begin
            tests++;
            fails++;
            $display("FAIL din_timeout: got din_ready=0 required 1");
        end else begin
            sb.push_back(e);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!done && t < 100);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got done=0 required 1");
        end else begin
            check("done_timing", 128'(cyc), 128'(last_acc_cyc + 1));
            check("busy_at_done", 128'(busy), 128'd0);
            @(negedge clk);
            #1;
            check("done_pulse", 128'(done), 128'd0);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int           n, lb, p0;
        logic [127:0] cb;
        exp_t         e;
        n  = (v.len + 15) / 16;
        lb = (v.len % 16 == 0) ? 16 : v.len % 16;
        p0 = pop_cnt;
        @(negedge clk);
        start  = 1'b1;
        icb_in = v.icb;
        len_in = 20'(v.len);
        @(negedge clk);
        start = 1'b0;
        if (v.busy_start) begin
            #1;
            check("busy_high", 128'(busy), 128'd1);
            @(negedge clk);
            start  = 1'b1;
            icb_in = '0;
            len_in = 20'd16;
            @(negedge clk);
            start = 1'b0;
        end
        cb = v.icb;
        for (int k = 0; k < n; k++) begin
            e.bytes = (k == n - 1) ? 5'(lb) : 5'd16;
            e.last  = (k == n - 1);
            e.blk   = (v.din ^ cb) & bmask(int'(e.bytes));
            send(v.din, e);
            cb = inc32(cb);
        end
        wait_done();
        check("block_count", 128'(pop_cnt - p0), 128'(v.exp_n));
        check("final_block", last_blk, v.exp_final);
        check("final_bytes", 128'(last_bytes), 128'(v.exp_lb));
    endtask

    initial begin
        vec_t         vecs[6];
        exp_t         e;
        logic [127:0] cb, held;
        int           p0, t;

        vecs[0] = '{128'h1, 16, '0, 1, 16, 128'h1, 1'b0};
        vecs[1] = '{128'h01234567_89ABCDEF_00112233_00000005, 48, '0,
                    3, 16, 128'h01234567_89ABCDEF_00112233_00000007, 1'b0};
        vecs[2] = '{128'h01234567_89ABCDEF_00112233_00000005, 20, '1,
                    2, 4, 128'hFEDCBA98_00000000_00000000_00000000, 1'b0};
        vecs[3] = '{128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF, 32, '0,
                    2, 16, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000000, 1'b0};
        vecs[4] = '{128'h8899AABB_CCDDEEFF_00112233_44556677, 1, '0,
                    1, 1, 128'h88000000_00000000_00000000_00000000, 1'b0};
        vecs[5] = '{128'h0F0E0D0C_0B0A0908_07060504_00000010, 32,
                    {16{8'h55}}, 2, 16,
                    128'h5A5B5859_5E5F5C5D_52535051_55555544, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_req_valid", 128'(aes_req_valid), 128'd0);
        check("rst_din_ready", 128'(din_ready), 128'd0);
        check("rst_dout_valid", 128'(dout_valid), 128'd0);
        check("rst_dout_last", 128'(dout_last), 128'd0);
        check("rst_dout_block", dout_block, 128'd0);
        check("rst_dout_bytes", 128'(dout_bytes), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i]);
        end
        repeat (4) @(negedge clk);
        #1;
        check("busy_start_ignored", 128'(busy), 128'd0);

        // Empty message: done next cycle, no AES traffic, no output.
        @(negedge clk);
        req_seen = 1'b0;
        p0 = pop_cnt;
        start  = 1'b1;
        icb_in = 128'h1234;
        len_in = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("empty_done", 128'(done), 128'd1);
        check("empty_busy", 128'(busy), 128'd0);
        @(negedge clk);
        #1;
        check("empty_done_pulse", 128'(done), 128'd0);
        repeat (5) @(negedge clk);
        #1;
        check("empty_no_req", 128'(req_seen), 128'd0);
        check("empty_no_dout", 128'(pop_cnt - p0), 128'd0);

        // Backpressure then reset during WAIT_KS.
        @(negedge clk);
        dout_ready = 1'b0;
        cb = 128'hDEADBEEF_01020304_CAFEF00D_00000100;
        start  = 1'b1;
        icb_in = cb;
        len_in = 20'd48;
        @(negedge clk);
        start = 1'b0;
        e.blk   = {16{8'h3C}} ^ cb;
        e.bytes = 5'd16;
        e.last  = 1'b0;
        send({16{8'h3C}}, e);
        cb = inc32(cb);
        #1;
        check("bp_dout_valid", 128'(dout_valid), 128'd1);
        held = dout_block;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din_block = {16{8'hC3}};
            din_valid = 1'b1;
            #1;
            check("bp_din_ready", 128'(din_ready), 128'd0);
            check("bp_dout_stable", dout_block, held);
        end
        @(negedge clk);
        dout_ready = 1'b1;
        e.blk = {16{8'hC3}} ^ cb;
        send({16{8'hC3}}, e);
        t = 0;
        #1;
        while (!aes_req_valid && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("bp_req_seen", 128'(aes_req_valid), 128'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_req_valid", 128'(aes_req_valid), 128'd0);
        check("mid_rst_din_ready", 128'(din_ready), 128'd0);
        check("mid_rst_dout_valid", 128'(dout_valid), 128'd0);
        check("mid_rst_dout_block", dout_block, 128'd0);
        check("mid_rst_dout_bytes", 128'(dout_bytes), 128'd0);
        check("mid_rst_dout_last", 128'(dout_last), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pop_cnt;
        repeat (8) @(negedge clk);
        #1;
        check("late_rsp_no_dout", 128'(dout_valid), 128'd0);
        check("late_rsp_idle", 128'(busy), 128'd0);
        check("late_rsp_no_pop", 128'(pop_cnt - p0), 128'd0);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
